// File: rtl/smiley_collision_detector.sv
// smiley_collision_detector
// Per-pixel collision detector for the smiley ball. It compares the smiley
// drawing request against the frame, obstacle, flipper, spring and bumper
// requests.
// Frame, obstacle and flipper contacts become registered per-pixel strobes.
// Spring and bumper contacts become one-shot pulses. Each re-arms only after
// one complete frame with no contact.
// A 4-bit {Left, Top, Right, Bottom} hit-edge code is registered together
// with the collision outputs.
// Optional feature macro: COLLISION_COUNTERS_EN adds a saturating 16-bit
// bumper hit counter on port bumperHitCount.
module smiley_collision_detector #(
  parameter int SMILEY_SIZE = 32,
  parameter int EDGE_WIDTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic        smileyDR,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        frameDR,
  input  logic        obstacleDR,
  input  logic        flipperDR,
  input  logic        springDR,
  input  logic        bumperDR,
  output logic        collisionSmileyFrame,
  output logic        collisionSmileyObstacle,
  output logic        collisionSmileyFlipper,
  output logic        collisionSmileySpringPulse,
  output logic        collisionSmileyBumperPulse,
  output logic [3:0]  hitEdgeCode
`ifdef COLLISION_COUNTERS_EN
  ,
  output logic [15:0] bumperHitCount
`endif
);

  // Edge band thresholds as 11-bit unsigned values for direct compare
  localparam logic [10:0] LP_EDGE_LO = 11'(EDGE_WIDTH);
  localparam logic [10:0] LP_EDGE_HI = 11'(SMILEY_SIZE - EDGE_WIDTH);

  // Index of each one-shot channel in the FSM arrays
  localparam int IDX_SPRING = 0;
  localparam int IDX_BUMPER = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  logic       w_qualify;
  logic       w_ov_frame;
  logic       w_ov_obstacle;
  logic       w_ov_flipper;
  logic [1:0] w_ov_oneshot;
  logic [3:0] w_edge_code;
  logic       w_any_next;

  state_t     r_state     [2];
  state_t     w_state_nxt [2];
  logic [1:0] r_seen;
  logic [1:0] w_seen_nxt;
  logic [1:0] w_fire_nxt;

  logic       r_frame;
  logic       r_obstacle;
  logic       r_flipper;
  logic       r_spring_pulse;
  logic       r_bumper_pulse;
  logic [3:0] r_hit_edge;

  // Qualified overlaps: masked in the frame-strobe cycle and while paused
  always_comb begin
    w_qualify     = ~startOfFrame & ~pause;
    w_ov_frame    = smileyDR & frameDR    & w_qualify;
    w_ov_obstacle = smileyDR & obstacleDR & w_qualify;
    w_ov_flipper  = smileyDR & flipperDR  & w_qualify;
    w_ov_oneshot[IDX_SPRING] = smileyDR & springDR & w_qualify;
    w_ov_oneshot[IDX_BUMPER] = smileyDR & bumperDR & w_qualify;
  end

  // Edge classification from the offsets inside the smiley square
  always_comb begin
    w_edge_code[3] = (offsetX <  LP_EDGE_LO);
    w_edge_code[2] = (offsetY <  LP_EDGE_LO);
    w_edge_code[1] = (offsetX >= LP_EDGE_HI);
    w_edge_code[0] = (offsetY >= LP_EDGE_HI);
  end

  // One-shot FSM next state and seen flags; everything holds while paused
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_seen_nxt[i]  = r_seen[i];
      if (pause) begin
        w_state_nxt[i] = r_state[i];
        w_seen_nxt[i]  = r_seen[i];
      end else if (startOfFrame) begin
        // Frame boundary: re-arm only if the previous frame had no contact
        w_seen_nxt[i] = 1'b0;
        case (r_state[i])
          ST_IDLE: w_state_nxt[i] = ST_IDLE;
          ST_FIRE: w_state_nxt[i] = ST_HELD;
          ST_HELD: begin
            if (r_seen[i]) begin
              w_state_nxt[i] = ST_HELD;
            end else begin
              w_state_nxt[i] = ST_IDLE;
            end
          end
          default: w_state_nxt[i] = ST_IDLE;
        endcase
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_ov_oneshot[i]) begin
              w_state_nxt[i] = ST_FIRE;
            end else begin
              w_state_nxt[i] = ST_IDLE;
            end
          end
          ST_FIRE: w_state_nxt[i] = ST_HELD;
          ST_HELD: begin
            if (w_ov_oneshot[i]) begin
              w_seen_nxt[i] = 1'b1;
            end else begin
              w_seen_nxt[i] = r_seen[i];
            end
          end
          default: w_state_nxt[i] = ST_IDLE;
        endcase
      end
      w_fire_nxt[i] = (w_state_nxt[i] == ST_FIRE) & ~pause;
    end
  end

  // Edge code loads whenever any collision output is high next cycle
  always_comb begin
    w_any_next = w_ov_frame | w_ov_obstacle | w_ov_flipper | (|w_fire_nxt);
  end

  // One-shot FSM state and seen flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state[IDX_SPRING] <= ST_IDLE;
      r_state[IDX_BUMPER] <= ST_IDLE;
      r_seen              <= 2'b00;
    end else begin
      r_state[IDX_SPRING] <= w_state_nxt[IDX_SPRING];
      r_state[IDX_BUMPER] <= w_state_nxt[IDX_BUMPER];
      r_seen              <= w_seen_nxt;
    end
  end

  // Registered collision outputs and hit-edge code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame        <= 1'b0;
      r_obstacle     <= 1'b0;
      r_flipper      <= 1'b0;
      r_spring_pulse <= 1'b0;
      r_bumper_pulse <= 1'b0;
      r_hit_edge     <= 4'b0000;
    end else begin
      r_frame        <= w_ov_frame;
      r_obstacle     <= w_ov_obstacle;
      r_flipper      <= w_ov_flipper;
      r_spring_pulse <= w_fire_nxt[IDX_SPRING];
      r_bumper_pulse <= w_fire_nxt[IDX_BUMPER];
      if (w_any_next) begin
        r_hit_edge <= w_edge_code;
      end else begin
        r_hit_edge <= r_hit_edge;
      end
    end
  end

  assign collisionSmileyFrame       = r_frame;
  assign collisionSmileyObstacle    = r_obstacle;
  assign collisionSmileyFlipper     = r_flipper;
  assign collisionSmileySpringPulse = r_spring_pulse;
  assign collisionSmileyBumperPulse = r_bumper_pulse;
  assign hitEdgeCode                = r_hit_edge;

`ifdef COLLISION_COUNTERS_EN
  logic [15:0] r_bumper_cnt;

  // Saturating count of bumper pulses; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bumper_cnt <= 16'h0000;
    end else if (r_bumper_pulse && (r_bumper_cnt != 16'hFFFF)) begin
      r_bumper_cnt <= r_bumper_cnt + 16'h0001;
    end else begin
      r_bumper_cnt <= r_bumper_cnt;
    end
  end

  assign bumperHitCount = r_bumper_cnt;
`endif

endmodule

// File: tb/tb_smiley_collision_detector.sv
// Self-checking bench for smiley_collision_detector: directed scenarios plus
// randomized traffic against a contact-episode reference model.
module tb_smiley_collision_detector;

  localparam int SZ = 32;
  localparam int EW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        pause = 1'b0;
  logic        smileyDR = 1'b0;
  logic [10:0] offsetX = 11'd0;
  logic [10:0] offsetY = 11'd0;
  logic        frameDR = 1'b0;
  logic        obstacleDR = 1'b0;
  logic        flipperDR = 1'b0;
  logic        springDR = 1'b0;
  logic        bumperDR = 1'b0;
  logic        collisionSmileyFrame;
  logic        collisionSmileyObstacle;
  logic        collisionSmileyFlipper;
  logic        collisionSmileySpringPulse;
  logic        collisionSmileyBumperPulse;
  logic [3:0]  hitEdgeCode;
`ifdef COLLISION_COUNTERS_EN
  logic [15:0] bumperHitCount;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: per one-shot channel (0 spring, 1 bumper)
  bit       m_armed   [2];
  bit       m_cool    [2];  // the sample right after a pulse never counts as contact
  bit       m_contact [2];  // contact seen in the current frame while disarmed
  bit       e_frame, e_obs, e_flip;
  bit [1:0] e_pulse;
  bit [3:0] e_hit;
  int       e_cnt;

  smiley_collision_detector #(.SMILEY_SIZE(SZ), .EDGE_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .smileyDR(smileyDR), .offsetX(offsetX), .offsetY(offsetY),
    .frameDR(frameDR), .obstacleDR(obstacleDR), .flipperDR(flipperDR),
    .springDR(springDR), .bumperDR(bumperDR),
    .collisionSmileyFrame(collisionSmileyFrame),
    .collisionSmileyObstacle(collisionSmileyObstacle),
    .collisionSmileyFlipper(collisionSmileyFlipper),
    .collisionSmileySpringPulse(collisionSmileySpringPulse),
    .collisionSmileyBumperPulse(collisionSmileyBumperPulse),
    .hitEdgeCode(hitEdgeCode)
`ifdef COLLISION_COUNTERS_EN
    , .bumperHitCount(bumperHitCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit [3:0] edge_of(int x, int y);
    return {x < EW, y < EW, x >= SZ - EW, y >= SZ - EW};
  endfunction

  function automatic bit [8:0] exp_vec();
    return {e_frame, e_obs, e_flip, e_pulse[0], e_pulse[1], e_hit};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {collisionSmileyFrame, collisionSmileyObstacle, collisionSmileyFlipper,
            collisionSmileySpringPulse, collisionSmileyBumperPulse, hitEdgeCode};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 1'b1; m_cool[i] = 1'b0; m_contact[i] = 1'b0;
    end
    e_frame = 0; e_obs = 0; e_flip = 0; e_pulse = 2'b00; e_hit = 4'b0000; e_cnt = 0;
  endtask

  // Advance the reference model by one sampled pixel
  task automatic model_step();
    bit live;
    bit [1:0] touch;
    if (e_pulse[1] && e_cnt < 65535) e_cnt++;
    live = !startOfFrame && !pause;
    touch = {smileyDR & bumperDR & live, smileyDR & springDR & live};
    e_frame = smileyDR & frameDR & live;
    e_obs   = smileyDR & obstacleDR & live;
    e_flip  = smileyDR & flipperDR & live;
    for (int i = 0; i < 2; i++) begin
      e_pulse[i] = 1'b0;
      if (pause) begin
        // frozen
      end else if (startOfFrame) begin
        if (!m_armed[i] && !m_cool[i] && !m_contact[i]) m_armed[i] = 1'b1;
        m_contact[i] = 1'b0;
        m_cool[i] = 1'b0;
      end else if (m_armed[i] && touch[i]) begin
        e_pulse[i] = 1'b1; m_armed[i] = 1'b0; m_cool[i] = 1'b1;
      end else if (m_cool[i]) begin
        m_cool[i] = 1'b0;
      end else if (!m_armed[i] && touch[i]) begin
        m_contact[i] = 1'b1;
      end
    end
    if (e_frame || e_obs || e_flip || (|e_pulse)) e_hit = edge_of(int'(offsetX), int'(offsetY));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic drive(bit sdr, bit f, bit o, bit fl, bit s, bit b, int x, int y);
    smileyDR = sdr; frameDR = f; obstacleDR = o; flipperDR = fl; springDR = s; bumperDR = b;
    offsetX = 11'(x); offsetY = 11'(y);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    if (dut_vec() !== 9'd0) begin
      errors++; $display("FAIL reset_state got %b exp %b", dut_vec(), 9'd0);
    end
    checks++;
    reset = 1'b0;
    tick();
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL after_reset got %b exp %b", dut_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_frame_strobe();
    drive(1, 1, 0, 0, 0, 0, 0, 10);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (dut_vec() !== exp_vec() || collisionSmileyFrame !== 1'b1 || hitEdgeCode !== 4'b1000) begin
        errors++; $display("FAIL frame_strobe cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 0, 0, 16, 16);
    tick();
    if (dut_vec() !== exp_vec() || collisionSmileyFrame !== 1'b0) begin
      errors++; $display("FAIL frame_strobe_end got %b exp %b", dut_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_corner();
    drive(1, 0, 1, 0, 0, 0, 31, 31);
    tick();
    if (dut_vec() !== exp_vec() || hitEdgeCode !== 4'b0011) begin
      errors++; $display("FAIL corner_code got %b exp %b", dut_vec(), exp_vec());
    end
    checks++;
    drive(1, 0, 0, 0, 0, 0, 16, 16);
    repeat (2) begin
      tick();
      if (dut_vec() !== exp_vec() || hitEdgeCode !== 4'b0011) begin
        errors++; $display("FAIL corner_hold got %b exp %b", dut_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  // One frame: frame strobe, n_touch bumper-overlap pixels, then n_idle quiet pixels
  task automatic bumper_frame(int n_touch, int n_idle, output int pulses);
    pulses = 0;
    drive(0, 0, 0, 0, 0, 0, 16, 16); startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    for (int c = 0; c < n_touch + n_idle; c++) begin
      if (c < n_touch) drive(1, 0, 0, 0, 0, 1, 16, 2);
      else drive(0, 0, 0, 0, 0, 0, 16, 16);
      tick();
      if (collisionSmileyBumperPulse === 1'b1) pulses++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL bumper_cycle got %b exp %b", dut_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_bumper_episode();
    int p;
    bumper_frame(5, 2, p);
    if (p !== 1) begin errors++; $display("FAIL bumper_f1 pulses %0d exp 1", p); end
    checks++;
    bumper_frame(3, 2, p);
    if (p !== 0) begin errors++; $display("FAIL bumper_f2 pulses %0d exp 0", p); end
    checks++;
    bumper_frame(0, 4, p);
    bumper_frame(3, 2, p);
    if (p !== 1) begin errors++; $display("FAIL bumper_f4 pulses %0d exp 1", p); end
    checks++;
`ifdef COLLISION_COUNTERS_EN
    if (bumperHitCount !== 16'd2 || int'(bumperHitCount) != e_cnt) begin
      errors++; $display("FAIL bumper_count got %0d exp 2", bumperHitCount);
    end
    checks++;
`endif
  endtask

  task automatic test_sof_mask();
    drive(1, 0, 0, 0, 1, 0, 5, 5); startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    if (collisionSmileySpringPulse !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL sof_mask got %b exp %b", dut_vec(), exp_vec());
    end
    checks++;
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    tick();
    if (collisionSmileySpringPulse !== 1'b0) begin
      errors++; $display("FAIL sof_mask_after got %b exp 0", collisionSmileySpringPulse);
    end
    checks++;
  endtask

  task automatic test_pause();
    drive(1, 0, 0, 1, 0, 0, 2, 2);
    tick();
    if (collisionSmileyFlipper !== 1'b1 || hitEdgeCode !== 4'b1100) begin
      errors++; $display("FAIL pause_pre got %b exp %b", dut_vec(), exp_vec());
    end
    checks++;
    pause = 1'b1; drive(1, 0, 0, 1, 0, 0, 31, 0);
    repeat (2) begin
      tick();
      if (collisionSmileyFlipper !== 1'b0 || hitEdgeCode !== 4'b1100 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL pause_frozen got %b exp %b", dut_vec(), exp_vec());
      end
      checks++;
    end
    pause = 1'b0;
    tick();
    if (collisionSmileyFlipper !== 1'b1 || hitEdgeCode !== 4'b0110) begin
      errors++; $display("FAIL pause_resume got %b exp %b", dut_vec(), exp_vec());
    end
    checks++;
    drive(0, 0, 0, 0, 0, 0, 16, 16);
    tick();
  endtask

  task automatic test_reset_mid_fire();
    drive(1, 0, 0, 0, 1, 0, 16, 16);
    tick();
    if (collisionSmileySpringPulse !== 1'b1) begin
      errors++; $display("FAIL fire_before_reset got %b exp 1", collisionSmileySpringPulse);
    end
    checks++;
    #1 reset = 1'b1;
    #1;
    if (dut_vec() !== 9'd0) begin
      errors++; $display("FAIL async_reset got %b exp %b", dut_vec(), 9'd0);
    end
    checks++;
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    if (collisionSmileySpringPulse !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL refire_after_reset got %b exp %b", dut_vec(), exp_vec());
    end
    checks++;
    tick();
    if (collisionSmileySpringPulse !== 1'b0) begin
      errors++; $display("FAIL single_refire got %b exp 0", collisionSmileySpringPulse);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      startOfFrame = (c % 24 == 0);
      pause = !startOfFrame && ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3, $urandom_range(0, 19) < 3,
            int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
      if ((c / 24) % 3 == 2) begin springDR = 1'b0; bumperDR = 1'b0; end
      tick();
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      checks++;
`ifdef COLLISION_COUNTERS_EN
      if (int'(bumperHitCount) != e_cnt) begin
        errors++; $display("FAIL random_count cyc %0d got %0d exp %0d", c, bumperHitCount, e_cnt);
      end
      checks++;
`endif
    end
    startOfFrame = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_strobe();
    test_corner();
    test_bumper_episode();
    test_sof_mask();
    test_pause();
    test_reset_mid_fire();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
